// File: rtl/counter_cmd_seq.sv
// Command sequencer feeding a saturating up/down counter: queues {dir, step, rep}
// commands in a small FIFO and replays each one as rep single-cycle up/dn strobes.
module counter_cmd_seq #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_dir,
   input  logic [7:0]               in_step,
   input  logic [3:0]               in_rep,
   input  logic                     hold,
   output logic                     up,
   output logic                     dn,
   output logic [7:0]               b,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef struct packed {
      logic       dir;
      logic [7:0] step;
      logic [3:0] rep;
   } cmd_t;

   typedef enum logic {
      S_IDLE,
      S_ISSUE
   } state_t;

   cmd_t          r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_cur_dir;
   logic [7:0]    r_cur_step;
   logic [3:0]    r_cur_rem;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_up;
   logic          w_dn;
   cmd_t          w_head;

   // A full FIFO refuses a push even when the same edge pops an entry.
   assign w_full  = (r_level == LW'(DEPTH));
   assign w_empty = (r_level == '0);
   assign w_push  = in_valid & ~w_full;
   assign w_head  = r_mem[r_rd_ptr];

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of the order the always_ff blocks are evaluated.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: every signal driven here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_up        = 1'b0;
      w_dn        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop = 1'b1;
               if (w_head.rep != 4'd0) begin
                  w_state_nxt = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            w_up = r_cur_dir & ~hold;
            w_dn = ~r_cur_dir & ~hold;
            if (!hold && (r_cur_rem == 4'd1)) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: the storage array has no reset; only pointers and level must be
   // cleared, and leaving the array unreset lets it map onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= cmd_t'({in_dir, in_step, in_rep});
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // b follows cur_step, which only changes when a command is popped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cur_dir  <= 1'b0;
         r_cur_step <= 8'd0;
         r_cur_rem  <= 4'd0;
      end else if (w_pop) begin
         r_cur_dir  <= w_head.dir;
         r_cur_step <= w_head.step;
         r_cur_rem  <= w_head.rep;
      end else if ((r_state == S_ISSUE) && !hold) begin
         r_cur_rem  <= r_cur_rem - 4'd1;
      end
   end

   assign up       = w_up;
   assign dn       = w_dn;
   assign b        = r_cur_step;
   assign busy     = (r_state == S_ISSUE) | ~w_empty;
   assign level    = r_level;
   assign in_ready = ~w_full;

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Bench for counter_cmd_seq: constant vector table, directed full-FIFO and
// async-reset sequences, and random traffic against a queue reference model.
module tb_counter_cmd_seq;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid = 1'b0;
   logic          in_dir = 1'b0;
   logic [7:0]    in_step = 8'd0;
   logic [3:0]    in_rep = 4'd0;
   logic          hold = 1'b0;
   logic          in_ready;
   logic          up;
   logic          dn;
   logic [7:0]    b;
   logic          busy;
   logic [LW-1:0] level;

   counter_cmd_seq #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_dir   (in_dir),
      .in_step  (in_step),
      .in_rep   (in_rep),
      .hold     (hold),
      .up       (up),
      .dn       (dn),
      .b        (b),
      .busy     (busy),
      .level    (level)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: command queue + issue state ----------
   typedef struct packed {
      logic       dir;
      logic [7:0] step;
      logic [3:0] rep;
   } cmd_t;

   cmd_t     m_q[$];
   bit       m_issue;
   bit       m_dir;
   bit [7:0] m_b;
   bit [3:0] m_rem;
   bit [3:0] m_cur_rep;
   bit       m_close;
   bit [3:0] m_close_rep;
   int       run_cnt;

   always @(posedge clk or negedge rst) begin
      int sz;
      if (!rst) begin
         m_q.delete();
         m_issue     <= 1'b0;
         m_dir       <= 1'b0;
         m_b         <= 8'd0;
         m_rem       <= 4'd0;
         m_cur_rep   <= 4'd0;
         m_close     <= 1'b0;
         m_close_rep <= 4'd0;
      end else begin
         sz = m_q.size();
         m_close <= 1'b0;
         if (m_issue) begin
            if (!hold) begin
               m_rem <= m_rem - 4'd1;
               if (m_rem == 4'd1) begin
                  m_issue     <= 1'b0;
                  m_close     <= 1'b1;
                  m_close_rep <= m_cur_rep;
               end
            end
         end else if (sz != 0) begin
            m_dir     <= m_q[0].dir;
            m_b       <= m_q[0].step;
            m_rem     <= m_q[0].rep;
            m_cur_rep <= m_q[0].rep;
            m_issue   <= (m_q[0].rep != 4'd0);
            if (m_q[0].rep == 4'd0) begin
               m_close     <= 1'b1;
               m_close_rep <= 4'd0;
            end
            void'(m_q.pop_front());
         end
         if (in_valid && (sz < DEPTH)) begin
            m_q.push_back(cmd_t'({in_dir, in_step, in_rep}));
         end
      end
   end

   // Per-cycle output check plus per-command strobe tally, sampled mid-cycle.
   always @(negedge clk or negedge rst) begin
      if (!rst) begin
         run_cnt <= 0;
      end else begin
         check("cycle {up,dn,b,busy,level,rdy}",
               32'({up, dn, b, busy, level, in_ready}),
               32'({m_issue & m_dir & ~hold, m_issue & ~m_dir & ~hold, m_b,
                    m_issue || (m_q.size() != 0), LW'(m_q.size()),
                    m_q.size() != DEPTH}));
         check("up&dn exclusive", 32'(up & dn), 32'(0));
         if (m_close) begin
            check("strobes per command", 32'(run_cnt), 32'(m_close_rep));
            run_cnt <= (up | dn) ? 1 : 0;
         end else begin
            run_cnt <= run_cnt + ((up | dn) ? 1 : 0);
         end
      end
   end

   // ---------------- vector table ------------------------------------------
   typedef struct {
      logic          vld;
      logic          dir;
      logic [7:0]    step;
      logic [3:0]    rep;
      logic          hld;
      logic [LW+11:0] exp;   // {up, dn, b, busy, level, in_ready}
   } vec_t;

   vec_t           vecs[$];
   logic [LW+11:0] exp_q[$];

   task automatic add(input logic vld, input logic dir, input logic [7:0] step,
                      input logic [3:0] rep, input logic hld,
                      input logic e_up, input logic e_dn, input logic [7:0] e_b,
                      input logic e_busy, input logic [LW-1:0] e_lvl, input logic e_rdy);
      vec_t v;
      v.vld  = vld;
      v.dir  = dir;
      v.step = step;
      v.rep  = rep;
      v.hld  = hld;
      v.exp  = {e_up, e_dn, e_b, e_busy, e_lvl, e_rdy};
      vecs.push_back(v);
   endtask

   task automatic push_cmd(input logic dir, input logic [7:0] step, input logic [3:0] rep);
      in_valid = 1'b1;
      in_dir   = dir;
      in_step  = step;
      in_rep   = rep;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      bit done = 1'b0;
      while (!done && (n < budget)) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      check("drain within budget", 32'(done), 32'(1));
      check("drained level", 32'(level), 32'(0));
   endtask

   initial begin
      logic [LW+11:0] e;
      bit seen;
      int n;
      int strobes;

      // {dir=1, step=5, rep=3}
      add(1, 1, 5, 3, 0,  0, 0, 5'd0, 0, 0, 1);
      add(0, 0, 0, 0, 0,  0, 0, 8'd0, 1, 1, 1);
      add(0, 0, 0, 0, 0,  1, 0, 8'd5, 1, 0, 1);
      add(0, 0, 0, 0, 0,  1, 0, 8'd5, 1, 0, 1);
      add(0, 0, 0, 0, 0,  1, 0, 8'd5, 1, 0, 1);
      add(0, 0, 0, 0, 0,  0, 0, 8'd5, 0, 0, 1);
      // rep=0 command is discarded, then {dir=0, step=2, rep=2}
      add(1, 0, 9, 0, 0,  0, 0, 8'd5, 0, 0, 1);
      add(1, 0, 2, 2, 0,  0, 0, 8'd5, 1, 1, 1);
      add(0, 0, 0, 0, 0,  0, 0, 8'd9, 1, 1, 1);
      add(0, 0, 0, 0, 0,  0, 1, 8'd2, 1, 0, 1);
      add(0, 0, 0, 0, 0,  0, 1, 8'd2, 1, 0, 1);
      add(0, 0, 0, 0, 0,  0, 0, 8'd2, 0, 0, 1);
      // {dir=1, step=1, rep=4} with hold for 3 cycles after the second strobe
      add(1, 1, 1, 4, 0,  0, 0, 8'd2, 0, 0, 1);
      add(0, 0, 0, 0, 0,  0, 0, 8'd2, 1, 1, 1);
      add(0, 0, 0, 0, 0,  1, 0, 8'd1, 1, 0, 1);
      add(0, 0, 0, 0, 0,  1, 0, 8'd1, 1, 0, 1);
      add(0, 0, 0, 0, 1,  0, 0, 8'd1, 1, 0, 1);
      add(0, 0, 0, 0, 1,  0, 0, 8'd1, 1, 0, 1);
      add(0, 0, 0, 0, 1,  0, 0, 8'd1, 1, 0, 1);
      add(0, 0, 0, 0, 0,  1, 0, 8'd1, 1, 0, 1);
      add(0, 0, 0, 0, 0,  1, 0, 8'd1, 1, 0, 1);
      add(0, 0, 0, 0, 0,  0, 0, 8'd1, 0, 0, 1);

      rst = 1'b1;
      #1 rst = 1'b0;
      #11;
      check("reset {up,dn,b,busy,level,rdy}",
            32'({up, dn, b, busy, level, in_ready}), 32'({2'b00, 8'd0, 1'b0, LW'(0), 1'b1}));
      @(posedge clk);
      #1 rst = 1'b1;

      // Each row: inputs held for one cycle, outputs observed mid-cycle.
      for (int i = 0; i < vecs.size(); i++) begin
         in_valid = vecs[i].vld;
         in_dir   = vecs[i].dir;
         in_step  = vecs[i].step;
         in_rep   = vecs[i].rep;
         hold     = vecs[i].hld;
         exp_q.push_back(vecs[i].exp);
         @(negedge clk);
         e = exp_q.pop_front();
         check($sformatf("vec %0d {up,dn,b,busy,level,rdy}", i),
               32'({up, dn, b, busy, level, in_ready}), 32'(e));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      hold     = 1'b0;

      // Fill the FIFO behind a long rep=15 command; a fifth push waits for space.
      push_cmd(1, 3, 15);
      push_cmd(0, 4, 1);
      push_cmd(1, 6, 2);
      push_cmd(0, 7, 3);
      push_cmd(1, 8, 1);
      @(negedge clk);
      check("full level", 32'(level), 32'(DEPTH));
      check("full in_ready", 32'(in_ready), 32'(0));
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_dir   = 1'b0;
      in_step  = 8'd9;
      in_rep   = 4'd5;
      seen     = 1'b0;
      n        = 0;
      while (!seen && (n < 40)) begin
         @(negedge clk);
         if (in_ready) begin
            seen = 1'b1;
            check("level after pop at full edge", 32'(level), 32'(DEPTH - 1));
         end else begin
            check("refused push keeps level", 32'(level), 32'(DEPTH));
         end
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      check("fifth push accepted after space", 32'(seen), 32'(1));
      wait_idle(200);

      // Asynchronous reset in mid-ISSUE with two commands queued.
      push_cmd(1, 2, 10);
      push_cmd(0, 3, 2);
      push_cmd(1, 4, 2);
      @(negedge clk);
      check("pre-reset up", 32'(up), 32'(1));
      check("pre-reset level", 32'(level), 32'(2));
      #2 rst = 1'b0;
      #1;
      check("async reset {up,dn,b,busy,level,rdy}",
            32'({up, dn, b, busy, level, in_ready}), 32'({2'b00, 8'd0, 1'b0, LW'(0), 1'b1}));
      @(posedge clk);
      #1 rst = 1'b1;
      strobes = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         strobes += (up | dn) ? 1 : 0;
         @(posedge clk);
         #1;
      end
      check("no strobe after reset", 32'(strobes), 32'(0));
      check("idle after reset busy", 32'(busy), 32'(0));

      // Random push/hold traffic; the model and monitor check every cycle.
      for (int i = 0; i < 600; i++) begin
         in_valid = ($urandom_range(0, 2) == 0);
         in_dir   = 1'($urandom_range(0, 1));
         in_step  = 8'($urandom_range(0, 255));
         in_rep   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(0, 3));
         hold     = ($urandom_range(0, 5) == 0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      hold     = 1'b0;
      wait_idle(400);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_cmd_seq.md
# counter_cmd_seq

Command sequencer that sits directly upstream of the saturating up/down counter and drives its `up`, `dn` and `b` inputs. Software or control logic pushes step commands (direction, step size, repeat count) through a valid/ready handshake into a small FIFO. The sequencer pops one command at a time and replays it as single-cycle counter strobes. It guarantees that `up` and `dn` are never asserted together and that `b` is stable whenever either strobe is high.

## Interface

Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, 2..16.

Ports:
- `clk`  in  1  rising-edge clock shared with the counter.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  command present on `in_dir`/`in_step`/`in_rep`.
- `in_ready`  out  1  FIFO can accept; equals not-full.
- `in_dir`  in  1  1 = count up, 0 = count down.
- `in_step`  in  8  step amount, forwarded to counter `b`.
- `in_rep`  in  4  number of strobes to issue (0..15).
- `hold`  in  1  pause issuing; the strobe count is preserved.
- `up`  out  1  counter up strobe.
- `dn`  out  1  counter down strobe.
- `b`  out  8  step value for the counter.
- `busy`  out  1  high in ISSUE state or when the FIFO is non-empty.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation

- Push: a command is written when `in_valid && in_ready` at a rising edge. `in_ready = (level != DEPTH)`. When full, `in_ready` is low and the command is not accepted, even if a pop occurs on the same edge.
- FIFO storage: 13 bits per entry {dir, step, rep}. Pointers wrap modulo DEPTH. `level` is 0..DEPTH.
- FSM states:
  - **IDLE**: if the FIFO is non-empty at an edge, pop the head into `cur_dir`, `cur_step` and `cur_rem = rep`.
    - If `rep != 0`, go to ISSUE.
    - If `rep == 0`, discard the command and stay in IDLE, ready to pop again next edge.
  - **ISSUE**:
    - `up = cur_dir & ~hold`; `dn = ~cur_dir & ~hold`.
    - Each edge with `hold == 0` decrements `cur_rem`.
    - When `cur_rem == 1` and `hold == 0`, go to IDLE after that edge.
    - With `hold == 1`, no strobe is issued and `cur_rem` is unchanged.
- `up`, `dn` outputs:
  - Decoded from registered state only; no input-to-output combinational path except `hold`.
  - Both are 0 in IDLE.
- `b` output:
  - Always `cur_step`, registered, updated only on pop.
  - Holds its last value in IDLE.
- Push and pop may occur on the same edge when the FIFO is neither full nor empty; `level` is unchanged in that case.
- A push into an empty FIFO while in IDLE is popped no earlier than the following edge (no bypass).
- Reset (asynchronous, `rst == 0`):
  - State goes to IDLE, FIFO pointers to 0.
  - Outputs: `up = 0`, `dn = 0`, `b = 0`, `busy = 0`, `level = 0`, `in_ready = 1`.
  - A reset in mid-ISSUE abandons the current command and all queued commands immediately. The strobe drops asynchronously.

## Timing

- Command accepted at edge E0 into an empty FIFO while IDLE:
  - Popped at E1.
  - `up`/`dn` high from after E1 until after E(1+rep).
  - The counter samples strobes at E2..E(1+rep).
- Back-to-back commands: one IDLE bubble cycle between the last strobe of one command and the first strobe of the next.
- Maximum throughput: rep strobes per rep+1 cycles.
- `hold` takes effect in the same cycle it is asserted (combinational gating). Each held cycle extends the command by one cycle.
- `busy` is registered-equivalent: it derives from state and `level` only.

## Test plan

- Reset then push {dir=1, step=5, rep=3} -> after pop, `up` is high for exactly 3 cycles with `b = 5`, `dn` stays 0, then `busy` falls to 0.
- Push four commands with `DEPTH = 4` while the first is issuing with rep=15:
  - `in_ready` drops when `level = 4`.
  - A fifth push is refused while full.
  - Commands are issued in order, each preceded by exactly one idle cycle.
- Push {dir=0, step=9, rep=0} followed by {dir=0, step=2, rep=2} -> the first command produces no strobe; `dn` is high for 2 cycles with `b = 2`.
- During {dir=1, step=1, rep=4}, assert `hold` for 3 cycles after the second strobe -> `up` is low for those 3 cycles, then exactly 2 more strobes follow (4 total).
- Assert `rst = 0` asynchronously mid-ISSUE with 2 commands queued -> `up`, `dn`, `b`, `level` and `busy` are 0 immediately; after release no strobe appears until a new push.
- Randomised push/hold traffic checked against a reference queue model:
  - `up & dn` is never 1.
  - Strobe totals per command equal rep.
  - `level` matches the model every cycle.
